// File: rtl/core_data_wb_bridge_if.sv
// Wishbone B4 pipelined bus bundle between the core data bridge (master) and the data interconnect (slave).
interface core_data_wb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic                  wb_stall_i;
  logic                  wb_ack_i;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_stall_i, wb_ack_i, wb_dat_i, wb_err_i
  );
endinterface

// File: rtl/core_data_wb_bridge.sv
// Pipelined Wishbone B4 master for the core data port: up to MAX_OUTSTANDING requests in flight, in-order responses.
// Optional response watchdog enabled by defining WB_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | nothing outstanding
// S_BUSY  | one or more requests issued and not yet acknowledged
// S_ABORT | single cycle after err/timeout, cyc low, all requests stalled
module core_data_wb_bridge #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                data_req_i,
  input  logic                data_wen_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_wmask_i,
  output logic                data_stall_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_valid_o,
  output logic                data_err_o,
  core_data_wb_bridge_if.master wb
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic can_issue;
  logic stb;
  logic accept;
  logic ack_v;
  logic err_v;
  logic timeout;

  assign can_issue = (state_q != S_ABORT) && (count_q < CNT_W'(MAX_OUTSTANDING));
  // reset_i gates the strobe so the bus is quiet for the whole reset pulse
  assign stb       = data_req_i & can_issue & reset_i;
  assign accept    = stb & ~wb.wb_stall_i;
  assign ack_v     = wb.wb_ack_i & (count_q != '0);
  assign err_v     = wb.wb_err_i & (count_q != '0);

  assign wb.wb_stb_o = stb;
  assign wb.wb_cyc_o = stb | (state_q == S_BUSY);
  assign wb.wb_we_o  = ~data_wen_i;
  assign wb.wb_adr_o = data_addr_i;
  assign wb.wb_dat_o = data_wdata_i;
  assign wb.wb_sel_o = data_wmask_i;

  assign data_stall_o = data_req_i & (~can_issue | wb.wb_stall_i | ~reset_i);
  assign data_valid_o = valid_q;
  assign data_err_o   = err_q;
  assign data_rdata_o = rdata_q;

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Fires on the cycle the counter would reach TIMEOUT_CYCLES, so the error pulse follows like a bus err.
  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if ((state_q == S_BUSY) && !wb.wb_ack_i && !accept) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (err_v || timeout) begin
      // remaining in-flight requests are dropped without individual responses
      err_d   = 1'b1;
      count_d = '0;
      state_d = S_ABORT;
    end else begin
      if (ack_v) begin
        valid_d = 1'b1;
        rdata_d = wb.wb_dat_i;
      end
      case ({accept, ack_v})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_BUSY;
        S_BUSY:  if (count_d == '0) state_d = S_IDLE;
        S_ABORT: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
